dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder for the RV32I core's load/store port. Accepts one request
//   at a time over a valid/ready handshake. Serves byte, half and word accesses with
//   RV32I funct3 semantics to a word-organised internal array. Inserts programmable
//   wait states and returns read data or an error over a held response channel.
// PARAMETERS
//   ADDR_W       8   byte-address width
//   DEPTH_WORDS  64  number of 32-bit words; legal word index 0..DEPTH_WORDS-1
//   WAIT_STATES  1   extra cycles between accept and response (0 allowed)
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous, active-high reset
//   req_valid   in   1       request present
//   req_ready   out  1       responder can accept (high only in IDLE)
//   req_we      in   1       1 = store, 0 = load
//   req_addr    in   ADDR_W  byte address
//   req_funct3  in   3       RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_wdata   in   32      store data, LSB-aligned
//   rsp_valid   out  1       response present, held until rsp_ready
//   rsp_ready   in   1       consumer accepts response
//   rsp_rdata   out  32      load result (extended); 0 for stores and errors
//   rsp_err     out  1       misaligned / illegal funct3 / out-of-range access
// BEHAVIOUR
//   Clock and reset: one clock domain, clk; rst is asynchronous and active-high.
//   Reset values
//   - State=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//   - Array contents are not reset. Reset mid-transaction aborts it; a pending
//     store is not written if the RESP entry edge has not yet occurred.
//   FSM IDLE -> WAIT -> RESP -> IDLE
//   - IDLE: req_ready=1. On req_valid at edge N, capture we/addr/funct3/wdata,
//     set cnt=WAIT_STATES, and go to WAIT.
//   - WAIT: req_ready=0. If cnt!=0, decrement. If cnt==0, at the next edge evaluate
//     the access, register rsp_*, perform any store, and go to RESP.
//   - RESP: rsp_valid=1. rsp_rdata and rsp_err are stable while rsp_ready=0. On
//     rsp_ready, next edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, go to IDLE.
//   Timing
//   - Latency: rsp_valid is first high after edge N+1+WAIT_STATES.
//   - Minimum spacing between accepts: WAIT_STATES+3 cycles.
//   - Request inputs are ignored outside IDLE.
//   Error checks (evaluated on the captured request)
//   - Half access (funct3[1:0]=01) with addr[0]!=0 -> err.
//   - Word access (funct3=010) with addr[1:0]!=0 -> err.
//   - Load funct3 in {011,110,111} -> err. Store funct3 > 010 -> err.
//   - addr[ADDR_W-1:2] >= DEPTH_WORDS -> err.
//   - On err: no array write, rsp_rdata=0, rsp_err=1.
//   Word selection: word index = addr[ADDR_W-1:2].
//   Loads (byte lane = addr[1:0], half lane = addr[1])
//   - LB/LH sign-extend the selected lane to 32 bits.
//   - LBU/LHU zero-extend the selected lane. LW returns the whole word.
//   Stores (byte-lane masked)
//   - SB writes wdata[7:0] to lane addr[1:0]. SH writes wdata[15:0] to half addr[1].
//     SW writes the whole word. Unselected lanes are preserved.
//   - The write occurs at the RESP entry edge, so any later load observes it.
// TESTING
//   1. Reset, WAIT_STATES=1; SW addr=0x10 data=0xDEADBEEF; then LW addr=0x10
//      -> rsp_rdata=0xDEADBEEF, err=0; rsp_valid rises 2 edges after accept.
//   2. After (1): LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE;
//      LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
//   3. SB addr=0x11 data=0x55, then LW 0x10 -> 0xDEAD55EF (other lanes kept).
//   4. LW 0x12 -> err=1, rdata=0. SH 0x11 -> err=1, and LW 0x10 still returns
//      0xDEAD55EF. LW 0x100-equivalent index 64 -> err=1.
//   5. Hold rsp_ready=0 for 5 cycles: rsp_valid/rdata stay stable and req_ready=0.
//      A req_valid pulse during this window is ignored.
//   6. Assert rst during WAIT of an SW 0x20=0x12345678 -> outputs go to reset values
//      immediately; a later LW 0x20 does not return 0x12345678 unless the word was
//      previously written with that value.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I load/store port.
// One request at a time over valid/ready, programmable wait states, then a
// held response carrying extended load data or an error flag.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  // The word index must be at least as wide as the array index.
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_funct3;
  logic [31:0]       cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic              accept;
  logic              eval;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              funct3_bad;
  logic              misaligned;
  logic              acc_err;
  logic [31:0]       load_data;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       merged;
  logic              wr_en;

  assign accept   = (state == S_IDLE) && req_valid;
  assign eval     = (state == S_WAIT) && (cnt == '0);
  assign word_idx = cap_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign in_range = 32'(word_idx) < DEPTH_WORDS;
  assign lane     = cap_addr[1:0];
  assign wr_en    = eval && cap_we && !acc_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture and wait-state counter; inputs are only sampled in IDLE.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_funct3 <= '0;
      cap_wdata  <= '0;
    end else if (accept) begin
      cnt        <= CNT_W'(WAIT_STATES);
      cap_we     <= req_we;
      cap_addr   <= req_addr;
      cap_funct3 <= req_funct3;
      cap_wdata  <= req_wdata;
    end else if ((state == S_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Access decode: error checks, load extension and byte-lane store merge.
  always_comb begin
    rd_word    = in_range ? mem[mem_idx] : '0;
    byte_sel   = rd_word[{lane, 3'b000} +: 8];
    half_sel   = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];
    funct3_bad = cap_we ? (cap_funct3 > 3'b010)
                        : ((cap_funct3 == 3'b011) || (cap_funct3[2:1] == 2'b11));
    misaligned = ((cap_funct3[1:0] == 2'b01) && cap_addr[0])
              || ((cap_funct3 == 3'b010) && (lane != 2'b00));
    acc_err    = funct3_bad || misaligned || !in_range;

    load_data = '0;
    unique case (cap_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase

    be    = 4'b0000;
    wlane = '0;
    unique case (cap_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wlane = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        be    = cap_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cap_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wlane = cap_wdata;
      end
      default: begin
        be    = 4'b0000;
        wlane = '0;
      end
    endcase

    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[i*8 +: 8] = wlane[i*8 +: 8];
    end
  end

  // Response registers: loaded on the RESP entry edge, cleared once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (eval) begin
      rsp_rdata <= (cap_we || acc_err) ? '0 : load_data;
      rsp_err   <= acc_err;
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  // Array write on the RESP entry edge; an aborted store never reaches here.
  // NOTE: the array has no reset, so it maps onto plain RAM and keeps contents across rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[mem_idx] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard.
// The DUT is built with a 9-bit address so word index 64 is reachable.
module tb_dmem_responder;

  localparam int ADDR_W      = 9;
  localparam int DEPTH_WORDS = 64;
  localparam int WAIT_STATES = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        ne;     // rdata must differ from the given value
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dmem_responder #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_STATES (WAIT_STATES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
    checks++;
    assert (obs !== bad) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected anything but 0x%08h", tag, obs, bad);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err, input logic ne);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.ne    = ne;
    sb.push_back(e);
  endtask

  // Present one request and return #1 after the accepting edge.
  task automatic send_req(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept"}, 32'(req_ready), 32'd1);
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  // Wait (bounded) for the response, check latency, pop and compare.
  task automatic wait_rsp(input string tag);
    int   lat = 0;
    exp_t e;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(1 + WAIT_STATES));
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.ne) check_ne({tag, " rdata"}, rsp_rdata, e.rdata);
      else      check({tag, " rdata"}, rsp_rdata, e.rdata);
      check({tag, " err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  // Consume the response and confirm the channel clears.
  task automatic release_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, " clear valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " clear rdata"}, rsp_rdata, 32'd0);
  endtask

  task automatic transact(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_err);
    push_exp(exp_rdata, exp_err, 1'b0);
    send_req(tag, we, addr, f3, wd);
    wait_rsp(tag);
    release_rsp(tag);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err",   32'(rsp_err), 32'd0);
    rst = 1'b0;

    // Word store then load.
    transact("sw_10",  1'b1, 9'h010, 3'b010, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
    transact("lw_10",  1'b0, 9'h010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0);

    // Sub-word loads with sign and zero extension.
    transact("lb_13",  1'b0, 9'h013, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
    transact("lbu_13", 1'b0, 9'h013, 3'b100, 32'h0, 32'h000000DE, 1'b0);
    transact("lh_12",  1'b0, 9'h012, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
    transact("lhu_10", 1'b0, 9'h010, 3'b101, 32'h0, 32'h0000BEEF, 1'b0);

    // Byte store keeps the other lanes.
    transact("sb_11",  1'b1, 9'h011, 3'b000, 32'hAAAAAA55, 32'h0, 1'b0);
    transact("lw_10b", 1'b0, 9'h010, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0);

    // Error cases, none of which may touch the array.
    transact("lw_12_mis",  1'b0, 9'h012, 3'b010, 32'h0,        32'h0, 1'b1);
    transact("sh_11_mis",  1'b1, 9'h011, 3'b001, 32'h1234,     32'h0, 1'b1);
    transact("st_f3_bad",  1'b1, 9'h010, 3'b011, 32'h0,        32'h0, 1'b1);
    transact("ld_f3_bad",  1'b0, 9'h010, 3'b110, 32'h0,        32'h0, 1'b1);
    transact("lw_10c",     1'b0, 9'h010, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0);
    transact("lw_idx64",   1'b0, 9'h100, 3'b010, 32'h0,        32'h0, 1'b1);
    transact("sw_idx64",   1'b1, 9'h100, 3'b010, 32'hCAFEF00D, 32'h0, 1'b1);

    // Last legal word, and a high-half store into it.
    transact("sw_idx63",   1'b1, 9'h0FC, 3'b010, 32'h01234567, 32'h0, 1'b0);
    transact("sh_fe",      1'b1, 9'h0FE, 3'b001, 32'h0000A5A5, 32'h0, 1'b0);
    transact("lw_idx63",   1'b0, 9'h0FC, 3'b010, 32'h0, 32'hA5A54567, 1'b0);

    // Hold the response for 5 cycles with a stray request in the middle.
    push_exp(32'hDEAD55EF, 1'b0, 1'b0);
    send_req("hold", 1'b0, 9'h010, 3'b010, 32'h0);
    wait_rsp("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        req_we     = 1'b1;
        req_addr   = 9'h010;
        req_funct3 = 3'b010;
        req_wdata  = 32'h0;
        req_valid  = 1'b1;
      end else begin
        req_valid  = 1'b0;
      end
      check("hold rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold rsp_rdata", rsp_rdata, 32'hDEAD55EF);
      check("hold req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    release_rsp("hold");
    transact("lw_after_hold", 1'b0, 9'h010, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0);

    // Reset during WAIT aborts the store.
    send_req("abort", 1'b1, 9'h020, 3'b010, 32'h12345678);
    #2;
    rst = 1'b1;
    #1;
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort rsp_rdata", rsp_rdata, 32'd0);
    check("abort rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp(32'h12345678, 1'b0, 1'b1);
    send_req("lw_20", 1'b0, 9'h020, 3'b010, 32'h0);
    wait_rsp("lw_20");
    release_rsp("lw_20");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
